mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one Wishbone-style data bus between the instruction-fetch port (M0) and the
//  load/store port of the memory stage (M1). Serialises accesses and drives pipeline stall
//  requests while a port waits. Returns read data with a one-cycle done pulse.
//  Sits between the IF/MEM stages and the external bus/RAM.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   32   data width; must be a multiple of 8
//  SEL_W    DATA_W/8   byte-select width (derived; do not override)
// PORTS
//  clk        in   1        clock
//  rst        in   1        synchronous reset, active-high
//  flush_i    in   1        pipeline flush; cancels result of in-flight/pending access
//  m0_req_i   in   1        IF request; held stable until m0_done_o
//  m0_addr_i  in   ADDR_W   IF address (read only)
//  m0_done_o  out  1        one-cycle pulse: IF access complete
//  m0_rdata_o out  DATA_W   IF read data, valid with done, held until next done
//  m0_stall_o out  1        stall request to pipeline for IF
//  m1_req_i   in   1        MEM request; held stable until m1_done_o
//  m1_we_i    in   1        MEM write enable
//  m1_addr_i  in   ADDR_W   MEM address
//  m1_sel_i   in   SEL_W    MEM byte selects
//  m1_wdata_i in   DATA_W   MEM write data
//  m1_done_o  out  1        one-cycle pulse: MEM access complete
//  m1_rdata_o out  DATA_W   MEM read data, valid with done, held until next done
//  m1_stall_o out  1        stall request to pipeline for MEM
//  wb_cyc_o, wb_stb_o  out  1   bus cycle/strobe (always asserted together)
//  wb_we_o    out  1        bus write enable
//  wb_adr_o   out  ADDR_W   bus address
//  wb_sel_o   out  SEL_W    bus byte selects (M0 drives all ones)
//  wb_dat_o   out  DATA_W   bus write data (zero for reads)
//  wb_dat_i   in   DATA_W   bus read data
//  wb_ack_i   in   1        bus acknowledge
// BEHAVIOUR
//  - Reset: state IDLE; all wb_* outputs 0; done 0; rdata 0; last_grant = M0; drop = 0.
//  - All bus outputs, done and rdata are registered. stall_o combinational:
//    mX_stall_o = mX_req_i & ~mX_done_o.
//  - FSM IDLE: if flush_i, no grant. Else if any req, pick winner, latch its addr/we/sel/wdata
//    into bus regs, assert cyc/stb -> BUSY. No req -> stay.
//  - Arbitration (default): fixed priority, M1 over M0.
//  - BUSY: bus outputs held constant. flush_i sets drop=1. On wb_ack_i: cyc/stb/we cleared;
//    if ~drop, capture wb_dat_i into winner's rdata (reads only; writes leave rdata unchanged)
//    and pulse winner's done; drop cleared -> IDLE.
//  - IDLE after completion is mandatory (1 bubble); no back-to-back grant from BUSY.
//  - Latency: req seen at edge N -> stb high after N; ack sampled at edge M (M>=N+1)
//    -> done high for cycle after M. Zero-wait-state bus: 3 cycles req-to-done, 4 per access.
//  - wb_ack_i in IDLE ignored. Request deassertion in BUSY is illegal (bus cycle completes).
//  - Reset mid-access: bus cycle dropped at next edge, no done; external slave assumed
//    reset by same rst.
//  - flush_i with ack on same edge: result dropped (no done).
// CONFIGURATION
//  - MEMARB_RR_EN defined: round-robin; when both req in IDLE, grant != last_grant;
//    last_grant updated on every grant. Single requester always wins immediately.
//  - Undefined: fixed priority M1 > M0; last_grant unused.
// STRUCTURE
//  - define.v: FSM state codes (ARB_IDLE, ARB_BUSY), master ids (ARB_M0, ARB_M1),
//    reuse ZeroWord/ChipEnable/WriteEnable.
//  - Sub-module arb_grant_sel: combinational winner pick from {req1,req0,last_grant};
//    holds the MEMARB_RR_EN switch.
// TESTING
//  1 M0 read alone, addr 0x100, slave acks 1 cycle after stb, dat 0xDEADBEEF
//    -> m0_done 3 cycles after req, m0_rdata=0xDEADBEEF, m0_stall high until done.
//  2 M1 write 0x12345678 sel 4'b0011 addr 0x204 -> wb_we=1, wb_sel=0011, wb_dat_o=0x12345678;
//    m1_done pulses, m1_rdata unchanged.
//  3 Both req every cycle, 4 accesses: fixed -> M1,M1,... M0 starved while M1 req;
//    MEMARB_RR_EN -> M1,M0,M1,M0.
//  4 flush_i in BUSY, ack 3 cycles later -> bus cycle completes, no done, rdata unchanged,
//    next req granted normally.
//  5 rst asserted while BUSY -> next cycle wb_cyc/stb=0, no done; later ack_i ignored.
//  6 Spurious wb_ack_i in IDLE, and flush_i in IDLE with req -> no done, no grant that cycle.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter:
// FSM state codes, master identifiers and common constants.
package mem_bus_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Bus master identifiers: M0 = instruction fetch, M1 = load/store
  typedef enum logic {
    ARB_M0 = 1'b0,
    ARB_M1 = 1'b1
  } arb_master_t;

  localparam logic        ChipEnable  = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

endpackage

// File: rtl/mem_bus_arbiter_grant_sel.sv
// Combinational winner selection for the memory bus arbiter.
// Optional feature macro: MEMARB_RR_EN (round-robin between M0 and M1);
// without it M1 has fixed priority over M0 and last_grant is ignored.
module mem_bus_arbiter_grant_sel
  import mem_bus_arbiter_pkg::*;
(
  input  logic        req0,
  input  logic        req1,
  input  arb_master_t last_grant,
  output logic        any_req,
  output arb_master_t winner
);

  assign any_req = req0 | req1;

`ifdef MEMARB_RR_EN
  // Round-robin: on contention the master that did not win last time goes next;
  // a lone requester always wins immediately.
  always_comb begin
    winner = ARB_M0;
    if (req0 && req1) begin
      winner = (last_grant == ARB_M1) ? ARB_M0 : ARB_M1;
    end else if (req1) begin
      winner = ARB_M1;
    end
  end
`else
  // Fixed priority: the memory stage always beats instruction fetch.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign winner = req1 ? ARB_M1 : ARB_M0;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master Wishbone-style bus arbiter between the IF port (M0) and the
// MEM load/store port (M1). One access at a time, one idle bubble between
// accesses, registered bus outputs, one-cycle done pulses with held read data.
// Optional feature macro: MEMARB_RR_EN (round-robin arbitration).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int SEL_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              m0_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  output logic              m0_done_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_stall_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_done_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_stall_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i
);

  localparam logic [DATA_W-1:0] ZERO_DATA = DATA_W'(ZeroWord);

  arb_state_t  state_reg, state_next;
  arb_master_t grant_reg, grant_next;
  arb_master_t last_grant_reg, last_grant_next;
  logic        drop_reg, drop_next;
  logic        cyc_reg, cyc_next;
  logic        we_reg, we_next;
  logic [ADDR_W-1:0] adr_reg, adr_next;
  logic [SEL_W-1:0]  sel_reg, sel_next;
  logic [DATA_W-1:0] dat_reg, dat_next;
  logic        m0_done_reg, m0_done_next;
  logic        m1_done_reg, m1_done_next;
  logic [DATA_W-1:0] m0_rdata_reg, m0_rdata_next;
  logic [DATA_W-1:0] m1_rdata_reg, m1_rdata_next;

  logic        any_req;
  arb_master_t winner;
  logic        discard;

  mem_bus_arbiter_grant_sel u_grant_sel (
    .req0       (m0_req_i),
    .req1       (m1_req_i),
    .last_grant (last_grant_reg),
    .any_req    (any_req),
    .winner     (winner)
  );

  // A flush arriving together with the ack cancels the result as well.
  assign discard = drop_reg | flush_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ARB_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: grant from IDLE unless flushing, return to IDLE on ack
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE: if (!flush_i && any_req) state_next = ARB_BUSY;
      ARB_BUSY: if (wb_ack_i)            state_next = ARB_IDLE;
      default:                           state_next = ARB_IDLE;
    endcase
  end

  // Output logic: next values of the registered bus signals, done pulses and read data
  always_comb begin
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    drop_next       = drop_reg;
    cyc_next        = cyc_reg;
    we_next         = we_reg;
    adr_next        = adr_reg;
    sel_next        = sel_reg;
    dat_next        = dat_reg;
    m0_done_next    = 1'b0;
    m1_done_next    = 1'b0;
    m0_rdata_next   = m0_rdata_reg;
    m1_rdata_next   = m1_rdata_reg;
    case (state_reg)
      ARB_IDLE: begin
        drop_next = 1'b0;
        if (!flush_i && any_req) begin
          grant_next      = winner;
          last_grant_next = winner;
          cyc_next        = ChipEnable;
          if (winner == ARB_M1) begin
            we_next  = m1_we_i;
            adr_next = m1_addr_i;
            sel_next = m1_sel_i;
            dat_next = (m1_we_i == WriteEnable) ? m1_wdata_i : ZERO_DATA;
          end else begin
            // Instruction fetch is always a full-width read
            we_next  = 1'b0;
            adr_next = m0_addr_i;
            sel_next = {SEL_W{1'b1}};
            dat_next = ZERO_DATA;
          end
        end
      end
      ARB_BUSY: begin
        if (wb_ack_i) begin
          cyc_next  = 1'b0;
          we_next   = 1'b0;
          drop_next = 1'b0;
          if (!discard) begin
            if (grant_reg == ARB_M1) begin
              m1_done_next = 1'b1;
              if (!we_reg) m1_rdata_next = wb_dat_i;
            end else begin
              m0_done_next  = 1'b1;
              m0_rdata_next = wb_dat_i;
            end
          end
        end else if (flush_i) begin
          // Bus cycle must still finish; only its result is thrown away
          drop_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered bus outputs, done pulses, read data and arbitration bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_reg      <= ARB_M0;
      last_grant_reg <= ARB_M0;
      drop_reg       <= 1'b0;
      cyc_reg        <= 1'b0;
      we_reg         <= 1'b0;
      adr_reg        <= '0;
      sel_reg        <= '0;
      dat_reg        <= '0;
      m0_done_reg    <= 1'b0;
      m1_done_reg    <= 1'b0;
      m0_rdata_reg   <= '0;
      m1_rdata_reg   <= '0;
    end else begin
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      drop_reg       <= drop_next;
      cyc_reg        <= cyc_next;
      we_reg         <= we_next;
      adr_reg        <= adr_next;
      sel_reg        <= sel_next;
      dat_reg        <= dat_next;
      m0_done_reg    <= m0_done_next;
      m1_done_reg    <= m1_done_next;
      m0_rdata_reg   <= m0_rdata_next;
      m1_rdata_reg   <= m1_rdata_next;
    end
  end

  assign wb_cyc_o   = cyc_reg;
  assign wb_stb_o   = cyc_reg;
  assign wb_we_o    = we_reg;
  assign wb_adr_o   = adr_reg;
  assign wb_sel_o   = sel_reg;
  assign wb_dat_o   = dat_reg;
  assign m0_done_o  = m0_done_reg;
  assign m1_done_o  = m1_done_reg;
  assign m0_rdata_o = m0_rdata_reg;
  assign m1_rdata_o = m1_rdata_reg;

  // Stall a pipeline stage while its request is outstanding
  assign m0_stall_o = m0_req_i & ~m0_done_reg;
  assign m1_stall_o = m1_req_i & ~m1_done_reg;

endmodule
